cacheline_adapter: RTL and testbench
====================================

// Module: cacheline_adapter
// PURPOSE
//  Sits directly below the 4-way data/instruction cache, on its dfp port.
//  Turns each 256-bit line read or writeback into a 4-beat x 64-bit burst on the banked-memory (bmem) port.
//  Assembles returning read beats into one line and answers the cache with a single-cycle dfp_resp.
// PARAMETERS
//  BEAT_W     64   width of one memory beat, in bits
//  BURST_LEN  4    beats per line; BEAT_W*BURST_LEN must equal 256
// PORTS
//  clk          in   1    clock; all state changes on the rising edge
//  rst          in   1    reset, synchronous and active-high
//  dfp_addr     in   32   line address from the cache; bits [4:0] are ignored
//  dfp_read     in   1    line fill request; held high until dfp_resp
//  dfp_write    in   1    line writeback request; held high until dfp_resp
//  dfp_wdata    in   256  writeback line; beat k = dfp_wdata[64k+63:64k]
//  dfp_rdata    out  256  assembled fill line; valid while dfp_resp=1
//  dfp_resp     out  1    one-cycle completion pulse for the current request
//  bmem_addr    out  32   burst address = {line_addr[31:5],5'b0}
//  bmem_read    out  1    read burst request; held until bmem_ready
//  bmem_write   out  1    write beat valid; beat k is sent in the k-th accepted cycle
//  bmem_wdata   out  64   current write beat
//  bmem_ready   in   1    memory accepts the read request or write beat this cycle
//  bmem_raddr   in   32   address tag of the returning read beat
//  bmem_rdata   in   64   returning read beat
//  bmem_rvalid  in   1    bmem_rdata/bmem_raddr valid this cycle
// BEHAVIOUR
//  Reset
//   - state=IDLE, beat counter=0.
//   - All outputs are 0, including dfp_rdata and the line buffer.
//   - rst in any state aborts the burst; bmem_read/bmem_write are 0 from the next cycle.
//   - Partially received beats are discarded and no dfp_resp is issued.
//  States: IDLE, RD_REQ, RD_DATA, WR_BURST, DONE.
//  IDLE
//   - On dfp_write: latch the line address and dfp_wdata, set cnt=0, go to WR_BURST.
//   - Else on dfp_read: latch the line address, go to RD_REQ.
//   - dfp_write wins if both requests are high.
//  RD_REQ
//   - bmem_read=1.
//   - On bmem_ready: cnt=0, go to RD_DATA.
//  RD_DATA
//   - On each bmem_rvalid with bmem_raddr == latched line address: buf[cnt]<=bmem_rdata, cnt++.
//   - A beat with a mismatching bmem_raddr is dropped.
//   - On an accepted beat with cnt==BURST_LEN-1: go to DONE.
//   - bmem_rvalid is ignored in every other state.
//  WR_BURST
//   - bmem_write=1; bmem_wdata=wbuf[cnt*64 +: 64].
//   - On bmem_ready: cnt++. When cnt==BURST_LEN-1 and bmem_ready: go to DONE.
//  DONE
//   - dfp_resp=1 for exactly one cycle, then go to IDLE.
//   - On a read, dfp_rdata = assembled line. On a write, dfp_rdata=0.
//  Request sampling
//   - Requests are sampled only in IDLE. dfp_* changes mid-burst are ignored.
//   - The cache deasserts its request the cycle after dfp_resp, so IDLE does not re-trigger.
//   - A writeback followed by a fill (WRITEBACK->ALLOCATE) takes back-to-back transactions, with no lost cycle beyond IDLE.
//  Latency, with memory always ready and data returned immediately
//   - Read: dfp_resp at cycle 6 after dfp_read is seen (1 IDLE + 1 RD_REQ + 4 beats).
//   - Write: dfp_resp at cycle 5 after dfp_write is seen.
//  Counter: cnt is 2 bits and wraps naturally; it never exceeds BURST_LEN-1 in a legal flow.
// TESTING
//  1. Read addr 0x1234_5678; memory returns beats 0x0..0,0x1..1,0x2..2,0x3..3
//     -> bmem_addr=0x1234_5660; dfp_rdata={3..3,2..2,1..1,0..0}; one dfp_resp.
//  2. Write line 0xAAAA..(256b), bmem_ready toggling 1,0,1,1,0,1
//     -> exactly 4 beats, in order from the low beat; dfp_resp only after the 4th accepted beat.
//  3. Writeback to 0x0000_0100, then fill from 0x0000_0200 (cache sequence)
//     -> two bursts with the correct addresses; two separate dfp_resp pulses.
//  4. bmem_rvalid with bmem_raddr=0xDEAD_0000 during a fill of 0x0000_0040
//     -> beat dropped; count unchanged; line still completes correctly.
//  5. rst asserted after 2 read beats -> IDLE; all outputs 0; no dfp_resp; next read completes normally.

Source files
------------

// File: rtl/cacheline_adapter_if.sv
// cacheline_adapter_if: cache-side (dfp) and memory-side (bmem) signals of the line adapter.
// The adapter takes the slave view; the environment (cache + memory) takes the master view.
interface cacheline_adapter_if #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
);
    localparam int LINE_W = BEAT_W * BURST_LEN;
    logic [31:0]       dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [31:0]       bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;
    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: splits 256-bit cache line fills/writebacks into 4 x 64-bit bmem bursts
// and reassembles returning read beats into one line with a single-cycle dfp_resp.
module cacheline_adapter #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
) (
    input logic           clk,
    input logic           rst,
    cacheline_adapter_if.slave bus
);
    localparam int LINE_W = BEAT_W * BURST_LEN;
    localparam int CNT_W  = $clog2(BURST_LEN);
    localparam logic [31:0] LINE_MASK = ~32'(LINE_W / 8 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_BURST, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] wbuf;
    logic [LINE_W-1:0] rbuf;
    logic              is_wr;
    logic              beat_ok;

    // Only beats tagged with our own line address count toward the fill.
    assign beat_ok = state_q == RD_DATA && bus.bmem_rvalid && bus.bmem_raddr == addr_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = bus.dfp_write ? WR_BURST : bus.dfp_read ? RD_REQ : IDLE;
            RD_REQ:   state_d = bus.bmem_ready ? RD_DATA : RD_REQ;
            RD_DATA:  state_d = (beat_ok && cnt == LAST) ? DONE : RD_DATA;
            WR_BURST: state_d = (bus.bmem_ready && cnt == LAST) ? DONE : WR_BURST;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            addr_q <= '0;
            wbuf   <= '0;
            rbuf   <= '0;
            is_wr  <= 1'b0;
        end else begin
            if (state_q == IDLE && (bus.dfp_write || bus.dfp_read)) begin
                addr_q <= bus.dfp_addr & LINE_MASK;
                is_wr  <= bus.dfp_write;
                cnt    <= '0;
                if (bus.dfp_write) wbuf <= bus.dfp_wdata;
            end
            if (state_q == RD_REQ && bus.bmem_ready) cnt <= '0;
            if (beat_ok) begin
                rbuf[cnt*BEAT_W +: BEAT_W] <= bus.bmem_rdata;
                cnt <= cnt + 1'b1;
            end
            if (state_q == WR_BURST && bus.bmem_ready) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        bus.dfp_resp   = state_q == DONE;
        bus.dfp_rdata  = (state_q == DONE && !is_wr) ? rbuf : '0;
        bus.bmem_addr  = addr_q;
        bus.bmem_read  = state_q == RD_REQ;
        bus.bmem_write = state_q == WR_BURST;
        bus.bmem_wdata = state_q == WR_BURST ? wbuf[cnt*BEAT_W +: BEAT_W] : '0;
    end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed checks of line fills, writebacks, dropped beats and reset abort.
module tb_cacheline_adapter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    cacheline_adapter_if bus ();
    cacheline_adapter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_resp"},  bus.dfp_resp,   1'b0);
        chk({tag, "_rdata"}, bus.dfp_rdata,  256'h0);
        chk({tag, "_rd"},    bus.bmem_read,  1'b0);
        chk({tag, "_wr"},    bus.bmem_write, 1'b0);
        chk({tag, "_wdata"}, bus.bmem_wdata, 64'h0);
        chk({tag, "_addr"},  bus.bmem_addr,  32'h0);
    endtask

    // Writeback: pat[i] is bmem_ready for the i-th WR_BURST cycle (repeats every 6).
    task automatic do_write(input logic [31:0] a, input logic [255:0] line,
                            input logic [5:0] pat, input logic both);
        int k = 0;
        int cyc = 0;
        bus.dfp_addr   = a;
        bus.dfp_wdata  = line;
        bus.dfp_write  = 1'b1;
        bus.dfp_read   = both;
        bus.bmem_ready = 1'b0;
        tick();
        bus.dfp_read  = 1'b0;
        bus.dfp_wdata = '1;
        bus.dfp_addr  = 32'hFFFF_FFE0;
        while (k < 4 && cyc < 20) begin
            bus.bmem_ready = pat[cyc % 6];
            chk("wr_valid", bus.bmem_write, 1'b1);
            chk("wr_rd_low", bus.bmem_read, 1'b0);
            chk("wr_addr", bus.bmem_addr, a & 32'hFFFF_FFE0);
            chk("wr_beat", bus.bmem_wdata, line[k*64 +: 64]);
            chk("wr_early_resp", bus.dfp_resp, 1'b0);
            tick();
            if (pat[cyc % 6]) k++;
            cyc++;
        end
        chk("wr_resp", bus.dfp_resp, 1'b1);
        chk("wr_rdata_zero", bus.dfp_rdata, 256'h0);
        chk("wr_done_nowrite", bus.bmem_write, 1'b0);
        bus.dfp_write  = 1'b0;
        bus.bmem_ready = 1'b1;
        tick();
        chk("wr_resp_pulse", bus.dfp_resp, 1'b0);
    endtask

    // Fill with immediate memory; inject adds a stray beat in RD_REQ and a foreign-tag beat before beat 2.
    task automatic do_read(input logic [31:0] a, input logic [255:0] line, input logic inject);
        logic [31:0] la;
        la = a & 32'hFFFF_FFE0;
        bus.dfp_addr   = a;
        bus.dfp_read   = 1'b1;
        bus.bmem_ready = 1'b1;
        tick();
        chk("rd_req", bus.bmem_read, 1'b1);
        chk("rd_addr", bus.bmem_addr, la);
        if (inject) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = la;
            bus.bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        tick();
        chk("rd_req_drop", bus.bmem_read, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (inject && k == 2) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_raddr  = 32'hDEAD_0000;
                bus.bmem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
                tick();
                chk("rd_bad_noresp", bus.dfp_resp, 1'b0);
            end
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = la;
            bus.bmem_rdata  = line[k*64 +: 64];
            chk("rd_noresp", bus.dfp_resp, 1'b0);
            tick();
        end
        bus.bmem_rvalid = 1'b0;
        bus.dfp_read    = 1'b0;
        chk("rd_resp", bus.dfp_resp, 1'b1);
        chk("rd_line", bus.dfp_rdata, line);
        tick();
        chk("rd_resp_pulse", bus.dfp_resp, 1'b0);
        chk("rd_rdata_idle", bus.dfp_rdata, 256'h0);
    endtask

    initial begin
        logic [255:0] l1, l2, l3, l4, l5;
        l1 = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
              64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
        l2 = {4{64'hAAAA_AAAA_AAAA_AAAA}};
        l3 = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
        l4 = {64'h4444_0003_0000_0040, 64'h4444_0002_0000_0040,
              64'h4444_0001_0000_0040, 64'h4444_0000_0000_0040};
        l5 = {64'h5555_5555_0000_0003, 64'h5555_5555_0000_0002,
              64'h5555_5555_0000_0001, 64'h5555_5555_0000_0000};
        bus.dfp_addr    = '0;
        bus.dfp_read    = 1'b0;
        bus.dfp_write   = 1'b0;
        bus.dfp_wdata   = '0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();
        chk("post_reset_resp", bus.dfp_resp, 1'b0);

        do_read(32'h1234_5678, l1, 1'b0);
        do_write(32'h0000_0300, l2, 6'b101101, 1'b1);
        do_write(32'h0000_0100, l3, 6'b111111, 1'b0);
        do_read(32'h0000_0200, l1, 1'b0);
        do_read(32'h0000_0040, l4, 1'b1);

        bus.dfp_addr   = 32'h0000_0080;
        bus.dfp_read   = 1'b1;
        bus.bmem_ready = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = 32'h0000_0080;
            bus.bmem_rdata  = l5[k*64 +: 64];
            tick();
        end
        bus.bmem_rvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dfp_read = 1'b0;
        chk_idle_outputs("abort");
        for (int k = 0; k < 4; k++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = 32'h0000_0000;
            tick();
            chk("abort_noresp", bus.dfp_resp, 1'b0);
        end
        bus.bmem_rvalid = 1'b0;
        do_read(32'h0000_0080, l5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
